// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ula_pkg
// Purpose  : Shared definitions for the arbitrated MIPS ALU: opcode values,
//            arbiter FSM state encoding and the default datapath width.
// Revision : 1.0 - initial release
// ============================================================================
package ula_pkg;

  localparam int LARGURA_PADRAO = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/ula_nucleo.sv
`default_nettype none
// ============================================================================
// Module   : ula_nucleo
// Purpose  : Combinational 32-bit MIPS ALU core (and/or/add/sub/slt).
//            Undefined opcodes give a zero result with the error flag set.
// Revision : 1.0 - initial release
// ============================================================================
module ula_nucleo
  import ula_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic [LARGURA-1:0] operador1,
  input  logic [LARGURA-1:0] operador2,
  input  logic [2:0]         opCode,
  output logic [LARGURA-1:0] resultado,
  output logic               isZero,
  output logic               erro
);

  // Decode the opcode and evaluate the selected operation.
  always_comb begin
    resultado = '0;
    erro      = 1'b0;
    case (opCode)
      OP_AND:  resultado = operador1 & operador2;
      OP_OR:   resultado = operador1 | operador2;
      OP_ADD:  resultado = operador1 + operador2;
      OP_SUB:  resultado = operador1 - operador2;
      OP_SLT:  resultado = {{(LARGURA-1){1'b0}},
                            ($signed(operador1) < $signed(operador2))};
      default: erro = 1'b1;
    endcase
    isZero = (resultado == '0);
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_ula.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_ula
// Purpose  : Shares one ALU core between the execute datapath (requester 0)
//            and the branch/PC unit (requester 1). One operation at a time:
//            accept -> execute -> hold response until the owner consumes it.
// Config   : ARBITRO_RR_EN defined   -> round-robin tie breaking.
//            ARBITRO_RR_EN undefined -> requester 0 always wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_ula
  import ula_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid0,
  input  logic               req_valid1,
  output logic               req_ready0,
  output logic               req_ready1,
  input  logic [LARGURA-1:0] operador1_0,
  input  logic [LARGURA-1:0] operador1_1,
  input  logic [LARGURA-1:0] operador2_0,
  input  logic [LARGURA-1:0] operador2_1,
  input  logic [2:0]         opCode0,
  input  logic [2:0]         opCode1,
  output logic               resp_valid0,
  output logic               resp_valid1,
  input  logic               resp_ready0,
  input  logic               resp_ready1,
  output logic [LARGURA-1:0] resultado,
  output logic               isZero,
  output logic               erro
);

  estado_t              state_q, state_d;
  logic [LARGURA-1:0]   op1_q, op1_d;
  logic [LARGURA-1:0]   op2_q, op2_d;
  logic [2:0]           opc_q, opc_d;
  logic                 owner_q, owner_d;
  logic [LARGURA-1:0]   res_q, res_d;
  logic                 zero_q, zero_d;
  logic                 erro_q, erro_d;
  logic                 rv0_q, rv0_d;
  logic                 rv1_q, rv1_d;

  logic [LARGURA-1:0]   core_res;
  logic                 core_zero;
  logic                 core_erro;

  logic                 prio;
  logic                 grant1;
  logic                 idle;
  logic                 accept;
  logic                 resp_ack;

`ifdef ARBITRO_RR_EN
  logic                 ptr_q, ptr_d;
  assign prio = ptr_q;
`else
  assign prio = 1'b0;
`endif

  // Requester 1 wins alone, or on a tie when the pointer favours it.
  // Ready is suppressed while reset is held so nothing looks accepted.
  assign grant1     = req_valid1 & (~req_valid0 | prio);
  assign idle       = reset & (state_q == OCIOSO);
  assign req_ready0 = idle & req_valid0 & ~grant1;
  assign req_ready1 = idle & grant1;
  assign accept     = req_ready0 | req_ready1;
  assign resp_ack   = (rv0_q & resp_ready0) | (rv1_q & resp_ready1);

  assign resp_valid0 = rv0_q;
  assign resp_valid1 = rv1_q;
  assign resultado   = res_q;
  assign isZero      = zero_q;
  assign erro        = erro_q;

  ula_nucleo #(
    .LARGURA (LARGURA)
  ) u_nucleo (
    .operador1 (op1_q),
    .operador2 (op2_q),
    .opCode    (opc_q),
    .resultado (core_res),
    .isZero    (core_zero),
    .erro      (core_erro)
  );

  // Next-state logic for the accept / execute / respond sequence.
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    owner_d = owner_q;
    res_d   = res_q;
    zero_d  = zero_q;
    erro_d  = erro_q;
    rv0_d   = rv0_q;
    rv1_d   = rv1_q;
`ifdef ARBITRO_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (accept) begin
          op1_d   = grant1 ? operador1_1 : operador1_0;
          op2_d   = grant1 ? operador2_1 : operador2_0;
          opc_d   = grant1 ? opCode1     : opCode0;
          owner_d = grant1;
          state_d = EXECUTA;
        end
      end
      EXECUTA: begin
        res_d   = core_res;
        zero_d  = core_zero;
        erro_d  = core_erro;
        rv0_d   = ~owner_q;
        rv1_d   = owner_q;
        state_d = RESPONDE;
      end
      RESPONDE: begin
        if (resp_ack) begin
          rv0_d   = 1'b0;
          rv1_d   = 1'b0;
          state_d = OCIOSO;
`ifdef ARBITRO_RR_EN
          ptr_d   = ~owner_q;
`endif
        end
      end
      default: begin
        state_d = OCIOSO;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= OCIOSO;
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= 3'b000;
      owner_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      erro_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
`ifdef ARBITRO_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      owner_q <= owner_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      erro_q  <= erro_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
`ifdef ARBITRO_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_ula.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_ula
// Purpose  : Directed self-checking bench for arbitro_ula.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_ula;

  logic        clock;
  logic        reset;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [31:0] operador1_0, operador1_1, operador2_0, operador2_1;
  logic [2:0]  opCode0, opCode1;
  logic        resp_valid0, resp_valid1;
  logic        resp_ready0, resp_ready1;
  logic [31:0] resultado;
  logic        isZero, erro;

  int n_cmp = 0;
  int n_bad = 0;

  arbitro_ula #(.LARGURA(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid0  (req_valid0),
    .req_valid1  (req_valid1),
    .req_ready0  (req_ready0),
    .req_ready1  (req_ready1),
    .operador1_0 (operador1_0),
    .operador1_1 (operador1_1),
    .operador2_0 (operador2_0),
    .operador2_1 (operador2_1),
    .opCode0     (opCode0),
    .opCode1     (opCode1),
    .resp_valid0 (resp_valid0),
    .resp_valid1 (resp_valid1),
    .resp_ready0 (resp_ready0),
    .resp_ready1 (resp_ready1),
    .resultado   (resultado),
    .isZero      (isZero),
    .erro        (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int req, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    if (req == 0) begin
      req_valid0 = v; operador1_0 = a; operador2_0 = b; opCode0 = op;
    end else begin
      req_valid1 = v; operador1_1 = a; operador2_1 = b; opCode1 = op;
    end
  endtask

  // Polls at falling edges until the given requester sees ready.
  task automatic wait_ready(input int req, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((req == 0 && req_ready0) || (req == 1 && req_ready1)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
    n_cmp++;
    n_bad++;
    $error("FAIL timeout_ready: observed no req_ready%0d expected req_ready%0d", req, req);
  endtask

  task automatic do_op(input string tag, input int req, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] er, input logic ez, input logic ee);
    bit ok;
    @(negedge clock);
    set_req(req, 1'b1, a, b, op);
    wait_ready(req, ok);
    if (!ok) begin
      set_req(req, 1'b0, a, b, op);
      return;
    end
    @(posedge clock); #1;
    set_req(req, 1'b0, a, b, op);
    @(negedge clock);
    chk({tag, "_exec_rv"}, {30'd0, resp_valid1, resp_valid0}, 32'd0);
    @(negedge clock);
    chk({tag, "_rv"}, {30'd0, resp_valid1, resp_valid0}, (req == 0) ? 32'd1 : 32'd2);
    chk({tag, "_res"}, resultado, er);
    chk({tag, "_zero"}, {31'd0, isZero}, {31'd0, ez});
    chk({tag, "_erro"}, {31'd0, erro}, {31'd0, ee});
    if (req == 0) resp_ready0 = 1'b1; else resp_ready1 = 1'b1;
    @(posedge clock); #1;
    resp_ready0 = 1'b0;
    resp_ready1 = 1'b0;
    chk({tag, "_done_rv"}, {30'd0, resp_valid1, resp_valid0}, 32'd0);
    chk({tag, "_hold_res"}, resultado, er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    logic [3:0] exp_g;
    time t_prev;
    reset = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    operador1_0 = '0; operador1_1 = '0; operador2_0 = '0; operador2_1 = '0;
    opCode0 = '0; opCode1 = '0;
    resp_ready0 = 1'b0; resp_ready1 = 1'b0;

    // Reset held with a pending request: everything quiet.
    set_req(0, 1'b1, 32'h7FFF_FFFF, 32'd1, 3'b010);
    #22;
    chk("rst_req_ready", {30'd0, req_ready1, req_ready0}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid1, resp_valid0}, 32'd0);
    chk("rst_resultado", resultado, 32'd0);
    chk("rst_flags", {30'd0, isZero, erro}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_release_ready0", {31'd0, req_ready0}, 32'd1);
    req_valid0 = 1'b0;

    do_op("add_wrap", 0, 32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000, 1'b0, 1'b0);
    do_op("sub_zero", 1, 32'd5, 32'd5, 3'b110, 32'd0, 1'b1, 1'b0);
    do_op("slt_neg", 0, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);
    do_op("slt_pos", 1, 32'd1, 32'hFFFF_FFFF, 3'b111, 32'd0, 1'b1, 1'b0);
    do_op("undef", 0, 32'h1234_5678, 32'h1111_1111, 3'b100, 32'd0, 1'b1, 1'b1);
    do_op("and", 1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, 32'h00F0_000F, 1'b0, 1'b0);
    do_op("or", 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b001, 32'hFFF0_0FFF, 1'b0, 1'b0);

    // Backpressure: owner 0 withholds resp_ready while requester 1 waits.
    @(negedge clock);
    set_req(0, 1'b1, 32'd10, 32'd20, 3'b010);
    wait_ready(0, ok);
    @(posedge clock); #1;
    set_req(0, 1'b0, 32'd10, 32'd20, 3'b010);
    set_req(1, 1'b1, 32'd3, 32'd4, 3'b110);
    @(negedge clock);
    chk("bp_exec_ready1", {31'd0, req_ready1}, 32'd0);
    @(negedge clock);
    chk("bp_rv", {30'd0, resp_valid1, resp_valid0}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_res_stable", resultado, 32'd30);
      chk("bp_ready1_low", {31'd0, req_ready1}, 32'd0);
      chk("bp_rv_held", {30'd0, resp_valid1, resp_valid0}, 32'd1);
    end
    resp_ready0 = 1'b1;
    @(posedge clock); #1;
    resp_ready0 = 1'b0;
    chk("bp_waiter_granted", {30'd0, req_ready1, req_ready0}, 32'd2);
    @(posedge clock); #1;
    set_req(1, 1'b0, 32'd3, 32'd4, 3'b110);
    @(negedge clock);
    @(negedge clock);
    chk("bp_waiter_rv", {30'd0, resp_valid1, resp_valid0}, 32'd2);
    chk("bp_waiter_res", resultado, 32'hFFFF_FFFF);
    resp_ready1 = 1'b1;
    @(posedge clock); #1;
    resp_ready1 = 1'b0;

    // Reset pulsed during execute drops the operation.
    @(negedge clock);
    set_req(0, 1'b1, 32'd1, 32'd2, 3'b010);
    wait_ready(0, ok);
    @(posedge clock); #1;
    set_req(0, 1'b0, 32'd1, 32'd2, 3'b010);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_res", resultado, 32'd0);
    chk("mid_rst_flags", {30'd0, isZero, erro}, 32'd0);
    chk("mid_rst_rv", {30'd0, resp_valid1, resp_valid0}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("mid_rst_no_resp", {30'd0, resp_valid1, resp_valid0}, 32'd0);
    do_op("after_rst", 1, 32'h1234_5678, 32'h1234_5678, 3'b110, 32'd0, 1'b1, 1'b0);

    // Tie arbitration with both requesters valid and responses always taken.
`ifdef ARBITRO_RR_EN
    exp_g = 4'b1010;
`else
    exp_g = 4'b0000;
`endif
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd1, 3'b010);
    set_req(1, 1'b1, 32'd2, 32'd2, 3'b010);
    resp_ready0 = 1'b1;
    resp_ready1 = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        #1;
        if (req_ready0 || req_ready1) begin
          ok = 1'b1;
          break;
        end
        @(negedge clock);
      end
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $error("FAIL tie_timeout: observed no grant expected grant %0d", k);
        break;
      end
      chk($sformatf("tie_grant%0d", k), {30'd0, req_ready1, req_ready0},
          exp_g[k] ? 32'd2 : 32'd1);
      if (k > 0) chk($sformatf("tie_gap%0d", k), 32'($time - t_prev), 32'd30);
      t_prev = $time;
      @(posedge clock);
      @(negedge clock);
    end
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    repeat (3) @(negedge clock);
    resp_ready0 = 1'b0;
    resp_ready1 = 1'b0;
    chk("tie_end_rv", {30'd0, resp_valid1, resp_valid0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
